sysid_check_ctrl: RTL and testbench



---
 rtl/sysid_check_pkg.sv | 23 ++
 rtl/sysid_lat_cnt.sv | 27 ++
 rtl/sysid_check_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_ID,
        ST_LAT_ID,
        ST_REQ_TS,
        ST_LAT_TS,
        ST_FIN
    } state_e;

    localparam logic        ADDR_ID         = 1'b0;
    localparam logic        ADDR_TS         = 1'b1;
    localparam logic [7:0]  TIMEOUT_LIMIT   = 8'd255;
    localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0001;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h5570_3D01;

    function automatic logic is_req(input state_e s);
        return (s == ST_REQ_ID) || (s == ST_REQ_TS);
    endfunction

endpackage

// File: rtl/sysid_lat_cnt.sv
// Loadable saturating down-counter; load has priority over decrement.
module sysid_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid reader: fetches ID and timestamp words and latches match status.
// Optional stall timeout enabled with macro SYSID_CHECK_TIMEOUT_EN.
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS = DEF_EXPECTED_TS,
    parameter int          RD_LATENCY  = 1,
    parameter int          AUTO_START  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
`ifdef SYSID_CHECK_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [31:0] ts_value
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY);

    state_e      state_q;
    logic        first_q;
    logic        m_read_q, m_address_q, busy_q, done_q, id_ok_q, ts_ok_q;
    logic [31:0] id_value_q, ts_value_q;
    logic [1:0]  lat_cnt;
    logic        accepted, lat_hit, to_expire;

    assign accepted = is_req(state_q) && !m_waitrequest;
    assign lat_hit  = (lat_cnt == 2'd1);

    sysid_lat_cnt #(.W(2)) u_lat_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (accepted),
        .val_i   (LAT_INIT),
        .dec_i   ((state_q == ST_LAT_ID) || (state_q == ST_LAT_TS)),
        .cnt_o   (lat_cnt)
    );

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic       timeout_q;
    logic [7:0] stall_cnt;

    // Reloaded on every non-stall cycle so only consecutive stalls count down.
    sysid_lat_cnt #(.W(8)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (!(is_req(state_q) && m_waitrequest)),
        .val_i   (TIMEOUT_LIMIT),
        .dec_i   (is_req(state_q) && m_waitrequest),
        .cnt_o   (stall_cnt)
    );

    assign to_expire = is_req(state_q) && m_waitrequest && (stall_cnt == 8'd1);
    assign timeout   = timeout_q;
`else
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b1;
            m_read_q    <= 1'b0;
            m_address_q <= ADDR_ID;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            id_value_q  <= '0;
            ts_value_q  <= '0;
`ifdef SYSID_CHECK_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            // NOTE: done defaults low each cycle so the FIN entry below yields a single-cycle pulse.
            done_q  <= 1'b0;
            first_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start || ((AUTO_START != 0) && first_q)) begin
                        state_q     <= ST_REQ_ID;
                        m_read_q    <= 1'b1;
                        m_address_q <= ADDR_ID;
                        busy_q      <= 1'b1;
                        id_ok_q     <= 1'b0;
                        ts_ok_q     <= 1'b0;
`ifdef SYSID_CHECK_TIMEOUT_EN
                        timeout_q   <= 1'b0;
`endif
                    end
                end
                ST_REQ_ID, ST_LAT_ID: begin
                    if (state_q == ST_REQ_ID && to_expire) begin
                        state_q  <= ST_FIN;
                        m_read_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end else if ((state_q == ST_REQ_ID && accepted && RD_LATENCY == 0) ||
                                 (state_q == ST_LAT_ID && lat_hit)) begin
                        id_value_q  <= m_readdata;
                        id_ok_q     <= (m_readdata == EXPECTED_ID);
                        state_q     <= ST_REQ_TS;
                        m_read_q    <= 1'b1;
                        m_address_q <= ADDR_TS;
                    end else if (state_q == ST_REQ_ID && accepted) begin
                        state_q  <= ST_LAT_ID;
                        m_read_q <= 1'b0;
                    end
                end
                ST_REQ_TS, ST_LAT_TS: begin
                    if (state_q == ST_REQ_TS && to_expire) begin
                        state_q  <= ST_FIN;
                        m_read_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end else if ((state_q == ST_REQ_TS && accepted && RD_LATENCY == 0) ||
                                 (state_q == ST_LAT_TS && lat_hit)) begin
                        ts_value_q <= m_readdata;
                        ts_ok_q    <= (m_readdata == EXPECTED_TS);
                        state_q    <= ST_FIN;
                        m_read_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (state_q == ST_REQ_TS && accepted) begin
                        state_q  <= ST_LAT_TS;
                        m_read_q <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state_q     <= ST_IDLE;
                    m_address_q <= ADDR_ID;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_read    = m_read_q;
    assign m_address = m_address_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign id_ok     = id_ok_q;
    assign ts_ok     = ts_ok_q;
    assign id_value  = id_value_q;
    assign ts_value  = ts_value_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with a latency-1 sysid slave model.
module tb_sysid_check_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        m_address, m_read, m_waitrequest;
    logic [31:0] m_readdata;
    logic        busy, done, id_ok, ts_ok;
    logic [31:0] id_value, ts_value;
`ifdef SYSID_CHECK_TIMEOUT_EN
    logic        timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] w0, w1;
    int          stall_n;
    int          stall_q;
    logic        force_wait;
    int          hold_err = 0;
    logic        prev_hold = 1'b0;
    logic        prev_addr = 1'b0;

    always #5 clock = ~clock;

    sysid_check_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .busy          (busy),
        .done          (done),
        .id_ok         (id_ok),
        .ts_ok         (ts_ok),
        .id_value      (id_value),
`ifdef SYSID_CHECK_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .ts_value      (ts_value)
    );

    // Slave: stalls stall_n cycles per read, returns data one cycle after acceptance.
    assign m_waitrequest = force_wait || (m_read && (stall_q < stall_n));

    always @(posedge clock) begin
        if (m_read && m_waitrequest) stall_q <= stall_q + 1;
        else if (m_read)             stall_q <= 0;
        if (m_read && !m_waitrequest) m_readdata <= m_address ? w1 : w0;
        else                          m_readdata <= 32'hDEAD_BEEF;
    end

    // A stalled request must keep m_read and m_address unchanged into the next cycle.
    always @(negedge clock) begin
        if (reset_n && prev_hold && !done && !(m_read && m_address == prev_addr))
            hold_err++;
        prev_hold = m_read && m_waitrequest;
        prev_addr = m_address;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; optionally pulses start, returns cycle count until done.
    task automatic run_seq(input logic do_start, input int budget, output int cycles);
        cycles = 0;
        start  = do_start;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            cycles++;
            if (done) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL done_wait: no done within %0d cycles", budget);
        cycles = -1;
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          stall;
        int          exp_cyc;
        logic        exp_id;
        logic        exp_ts;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        int dones;
        int busy_late;

        vecs[0] = '{32'h0000_0001, 32'h5570_3D01, 0, 5,  1'b1, 1'b1};
        vecs[1] = '{32'h0000_0001, 32'h5570_3D00, 0, 5,  1'b1, 1'b0};
        vecs[2] = '{32'h0000_0002, 32'h5570_3D01, 0, 5,  1'b0, 1'b1};
        vecs[3] = '{32'h0000_0001, 32'h5570_3D01, 3, 11, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1, 7,  1'b0, 1'b0};

        reset_n    = 1'b0;
        start      = 1'b0;
        force_wait = 1'b0;
        stall_n    = 0;
        stall_q    = 0;
        w0         = 32'h0000_0001;
        w1         = 32'h5570_3D01;

        repeat (3) @(negedge clock);
        check("rst_m_read",   {31'd0, m_read},  32'd0);
        check("rst_busy",     {31'd0, busy},    32'd0);
        check("rst_done",     {31'd0, done},    32'd0);
        check("rst_id_ok",    {31'd0, id_ok},   32'd0);
        check("rst_ts_value", ts_value,         32'd0);

        // Auto-start after reset release, followed cycle by cycle.
        reset_n = 1'b1;
        @(posedge clock); @(negedge clock);
        check("auto_c1_read", {30'd0, m_read, m_address}, 32'b10);
        check("auto_c1_busy", {31'd0, busy}, 32'd1);
        @(posedge clock); @(negedge clock);
        check("auto_c2_read", {31'd0, m_read}, 32'd0);
        @(posedge clock); @(negedge clock);
        check("auto_c3_read", {30'd0, m_read, m_address}, 32'b11);
        @(posedge clock); @(negedge clock);
        check("auto_c4_read", {31'd0, m_read}, 32'd0);
        check("auto_c4_done", {31'd0, done}, 32'd0);
        @(posedge clock); @(negedge clock);
        check("auto_c5_done", {30'd0, done, busy}, 32'b10);
        check("auto_ok",      {30'd0, id_ok, ts_ok}, 32'b11);
        check("auto_ts_val",  ts_value, 32'h5570_3D01);
        @(posedge clock); @(negedge clock);
        check("auto_c6_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            w0      = vecs[i].w0;
            w1      = vecs[i].w1;
            stall_n = vecs[i].stall;
            run_seq(1'b1, 100, cyc);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_id_ok", i), {31'd0, id_ok}, {31'd0, vecs[i].exp_id});
            check($sformatf("v%0d_ts_ok", i), {31'd0, ts_ok}, {31'd0, vecs[i].exp_ts});
            check($sformatf("v%0d_id_val", i), id_value, vecs[i].w0);
            check($sformatf("v%0d_ts_val", i), ts_value, vecs[i].w1);
            repeat (2) @(negedge clock);
            check($sformatf("v%0d_hold_ok", i), {31'd0, id_ok}, {31'd0, vecs[i].exp_id});
        end
        check("stall_hold", hold_err, 0);
        stall_n = 0;
        w0 = 32'h0000_0001;
        w1 = 32'h5570_3D01;

        // Start during LAT_TS and during FIN is ignored.
        dones = 0;
        busy_late = 0;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); @(negedge clock);
            start = (k == 4 || k == 5);
            if (done) dones++;
            if (k >= 6 && busy) busy_late++;
        end
        check("ign_done_count", dones, 1);
        check("ign_no_restart", busy_late, 0);
        w1 = 32'h1234_5678;
        run_seq(1'b1, 100, cyc);
        check("fresh_cycles", cyc, 5);
        check("fresh_ts_val", ts_value, 32'h1234_5678);
        check("fresh_ts_ok",  {31'd0, ts_ok}, 32'd0);
        w1 = 32'h5570_3D01;
        repeat (2) @(negedge clock);

        // Asynchronous reset during REQ_TS.
        start = 1'b1;
        @(posedge clock); @(negedge clock); start = 1'b0;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        check("pre_rst_read", {30'd0, m_read, m_address}, 32'b11);
        reset_n = 1'b0;
        #1;
        check("mid_rst_read",  {30'd0, m_read, m_address}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_id_ok", {31'd0, id_ok}, 32'd0);
        check("mid_rst_id_val", id_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_seq(1'b0, 100, cyc);
        check("rerun_cycles", cyc, 5);
        check("rerun_ok", {30'd0, id_ok, ts_ok}, 32'b11);
        repeat (2) @(negedge clock);

`ifdef SYSID_CHECK_TIMEOUT_EN
        force_wait = 1'b1;
        run_seq(1'b1, 400, cyc);
        check("to_cycles",  cyc, 256);
        check("to_flag",    {31'd0, timeout}, 32'd1);
        check("to_ok",      {30'd0, id_ok, ts_ok}, 32'd0);
        check("to_busy",    {31'd0, busy}, 32'd0);
        force_wait = 1'b0;
        repeat (2) @(negedge clock);
        run_seq(1'b1, 100, cyc);
        check("to_clear",   {31'd0, timeout}, 32'd0);
        check("to_rerun_ok", {30'd0, id_ok, ts_ok}, 32'b11);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
